// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared encodings for the memory arbiter (FSM states, port IDs, cache ops).
// Revision 1.0
`default_nettype none

package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } op_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

`default_nettype wire

// File: rtl/arb_pick.sv
// arb_pick: combinational winner selection between instruction and data requests.
// Macro ARB_ROUND_ROBIN_EN selects round-robin (else fixed data-over-instruction priority). Revision 1.0
`default_nettype none

module arb_pick
  import mem_arb_pkg::*;
(
  input  logic ireq_i,
  input  logic dreq_i,
  input  logic last_i,
  output logic grant_o
);

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    grant_o = PORT_I;
    if (ireq_i && dreq_i) begin
      grant_o = (last_i == PORT_I) ? PORT_D : PORT_I;
    end else if (dreq_i) begin
      grant_o = PORT_D;
    end
  end
`else
  logic unused_inputs;

  // Fixed priority never looks at the instruction request or the history bit.
  assign unused_inputs = ireq_i ^ last_i;

  always_comb begin
    grant_o = dreq_i ? PORT_D : PORT_I;
  end
`endif

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one cache port between instruction-fetch and data requesters.
// Arbitration policy set by ARB_ROUND_ROBIN_EN (see arb_pick). Revision 1.0
`default_nettype none

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_stall,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_stall,
  output logic              m_read,
  output logic              m_write,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_stall
);

  state_t            state_q,   state_d;
  op_t               op_q,      op_d;
  logic              grant_q,   grant_d;
  logic              last_q,    last_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic [DATA_W-1:0] wdata_q,   wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic ireq;
  logic dreq;
  logic pick;

  assign ireq = i_read;
  assign dreq = d_read | d_write;

  arb_pick u_arb_pick (
    .ireq_i  (ireq),
    .dreq_i  (dreq),
    .last_i  (last_q),
    .grant_o (pick)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_NONE;
      grant_q   <= PORT_I;
      last_q    <= PORT_I;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    grant_d   = grant_q;
    last_d    = last_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (ireq || dreq) begin
          state_d = ST_BUSY;
          grant_d = pick;
          last_d  = pick;
          if (pick == PORT_D) begin
            // A simultaneous read+write is a write; the read is dropped.
            op_d    = d_write ? OP_WRITE : OP_READ;
            addr_d  = d_addr;
            wdata_d = d_wdata;
          end else begin
            op_d   = OP_READ;
            addr_d = i_addr;
          end
        end
      end
      ST_BUSY: begin
        if (!m_stall) begin
          state_d = ST_DONE;
          if (op_q == OP_READ) begin
            if (grant_q == PORT_I) begin
              i_rdata_d = m_rdata;
            end else begin
              d_rdata_d = m_rdata;
            end
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Cache-side signals come only from latched state so the cache sees a stable request.
  assign m_read  = (state_q == ST_BUSY) && (op_q == OP_READ);
  assign m_write = (state_q == ST_BUSY) && (op_q == OP_WRITE);
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;

  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign i_stall = ireq & ~((state_q == ST_DONE) && (grant_q == PORT_I));
  assign d_stall = dreq & ~((state_q == ST_DONE) && (grant_q == PORT_D));

endmodule

`default_nettype wire
